// File: rtl/hex_scan_display_if.sv
// Display-side bus of hex_scan_display: value/control in, segment/anode/frame out.
interface hex_scan_display_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4*DIGITS-1:0] VALUE;
    logic                LOAD;
    logic                BLANK_LZ;
    logic [DIGITS-1:0]   BLINK_EN;
    logic [6:0]          SEG;
    logic [DIGITS-1:0]   AN;
    logic                FRAME;

    modport master (
        output VALUE, LOAD, BLANK_LZ, BLINK_EN,
        input  SEG, AN, FRAME
    );

    modport slave (
        input  VALUE, LOAD, BLANK_LZ, BLINK_EN,
        output SEG, AN, FRAME
    );
endinterface

// File: rtl/hex_scan_display.sv
// Time-multiplexed seven-segment driver: shadowed hex value, prescaled digit scan,
// leading-zero suppression and per-digit blinking with registered SEG/AN/FRAME.
module hex_scan_display #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned PRESCALE  = 1000,
    parameter int unsigned BLINK_DIV = 64
) (
    input  logic              clk,
    input  logic              rst,
    hex_scan_display_if.slave bus
);
    localparam int unsigned VW = 4 * DIGITS;
    localparam int unsigned PW = (PRESCALE  > 1) ? $clog2(PRESCALE)  : 1;
    localparam int unsigned IW = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [VW-1:0]     pend_q, pend_d;
    logic              flag_q, flag_d;
    logic [VW-1:0]     disp_q, disp_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic              phase_q, phase_d;
    logic              wrap_q, wrap_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              frame_q, frame_d;

    logic              slot_end;
    logic              wrap;
    logic [3:0]        nib;
    logic              hi_zero;
    logic              suppress;
    logic              blink_off;
    logic [DIGITS-1:0] onehot;

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1110111;
            4'h1:    s = 7'b0100100;
            4'h2:    s = 7'b1011101;
            4'h3:    s = 7'b1101101;
            4'h4:    s = 7'b0101110;
            4'h5:    s = 7'b1101011;
            4'h6:    s = 7'b1111011;
            4'h7:    s = 7'b0100101;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b0111111;
            4'hB:    s = 7'b1111010;
            4'hC:    s = 7'b1010011;
            4'hD:    s = 7'b1111100;
            4'hE:    s = 7'b1011011;
            default: s = 7'b0011011;
        endcase
        return s;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q  <= '0;
            idx_q   <= '0;
            pend_q  <= '0;
            flag_q  <= 1'b0;
            disp_q  <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            wrap_q  <= 1'b0;
            seg_q   <= '0;
            an_q    <= '0;
            frame_q <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            flag_q  <= flag_d;
            disp_q  <= disp_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    // Scan timing, value shadowing and blink phase
    always_comb begin
        pcnt_d   = pcnt_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        flag_d   = flag_q;
        disp_d   = disp_q;
        bcnt_d   = bcnt_q;
        phase_d  = phase_q;
        slot_end = (pcnt_q == PW'(PRESCALE - 1));
        wrap     = slot_end && (idx_q == IW'(DIGITS - 1));
        wrap_d   = wrap;

        if (slot_end) begin
            pcnt_d = '0;
            idx_d  = wrap ? '0 : idx_q + IW'(1);
        end else begin
            pcnt_d = pcnt_q + PW'(1);
        end

        if (bus.LOAD) begin
            pend_d = bus.VALUE;
            flag_d = 1'b1;
        end

        // Display only changes at the frame boundary; a LOAD in that cycle wins outright.
        if (wrap) begin
            if (bus.LOAD) begin
                disp_d = bus.VALUE;
            end else if (flag_q) begin
                disp_d = pend_q;
            end
            flag_d = 1'b0;
            if (bcnt_q == BW'(BLINK_DIV - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    // Output decode for the digit currently addressed by idx
    always_comb begin
        nib       = 4'h0;
        hi_zero   = 1'b1;
        suppress  = 1'b0;
        blink_off = 1'b0;
        onehot    = '0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            hi_zero = hi_zero && (disp_q[4*k +: 4] == 4'h0);
            if (IW'(k) == idx_q) begin
                nib       = disp_q[4*k +: 4];
                suppress  = bus.BLANK_LZ && hi_zero && (k != 0);
                blink_off = bus.BLINK_EN[k] && phase_q;
                onehot[k] = 1'b1;
            end
        end
        seg_d   = (suppress || blink_off) ? 7'b0000000 : seg_code(nib);
        an_d    = (suppress || blink_off) ? '0 : onehot;
        frame_d = wrap_q;
    end

    assign bus.SEG   = seg_q;
    assign bus.AN    = an_q;
    assign bus.FRAME = frame_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench for hex_scan_display (DIGITS=4, PRESCALE=4, BLINK_DIV=2).
module tb_hex_scan_display;
    typedef struct {
        int         cyc;
        logic [6:0] seg;
        logic [3:0] an;
        logic       frame;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];

    localparam logic [6:0] C0 = 7'b1110111;
    localparam logic [6:0] C1 = 7'b0100100;
    localparam logic [6:0] C3 = 7'b1101101;
    localparam logic [6:0] C4 = 7'b0101110;
    localparam logic [6:0] CA = 7'b0111111;
    localparam logic [6:0] CF = 7'b0011011;

    hex_scan_display_if #(.DIGITS(4)) bus ();

    hex_scan_display #(.DIGITS(4), .PRESCALE(4), .BLINK_DIV(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Cycle n = number of clock edges since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: the DUT presents a new SEG/AN/FRAME every cycle; check queued expectations.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_vec++;
            if (e.cyc != cyc || bus.SEG !== e.seg || bus.AN !== e.an || bus.FRAME !== e.frame) begin
                n_err++;
                $display("FAIL %s cyc=%0d(exp %0d): SEG=%b AN=%b FRAME=%b, required SEG=%b AN=%b FRAME=%b",
                         e.tag, cyc, e.cyc, bus.SEG, bus.AN, bus.FRAME, e.seg, e.an, e.frame);
            end
        end
    end

    // Expected outputs for the first ncyc cycles of frame f; s3..s0 are per-digit codes.
    task automatic push_frame(input int f, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input logic [3:0] lit, input int ncyc, input string tag);
        logic [6:0] sv [4];
        logic [3:0] bit1;
        exp_t e;
        sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
        for (int c = 0; c < ncyc; c++) begin
            int d;
            d     = c / 4;
            bit1  = 4'b0001 << d;
            e.cyc = 16 * f + c + 1;
            e.seg = lit[d] ? sv[d] : 7'b0000000;
            e.an  = lit[d] ? bit1 : 4'b0000;
            e.frame = (f > 0) && (c == 0);
            e.tag = tag;
            q.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int n);
        int budget = 0;
        while (cyc < n && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        if (cyc < n) begin
            n_err++;
            $display("FAIL wait_cyc timeout: cyc=%0d, required %0d", cyc, n);
        end
    endtask

    task automatic wait_drain();
        int budget = 0;
        while (q.size() > 0 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain timeout: %0d expectations left, required 0", q.size());
        end
    endtask

    task automatic do_reset();
        exp_t e;
        #2;
        rst   = 1'b1;
        e.cyc = 0; e.seg = 7'b0000000; e.an = 4'b0000; e.frame = 1'b0; e.tag = "reset";
        q.push_back(e);
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_at(input int n, input logic [15:0] v);
        wait_cyc(n - 1);
        bus.VALUE = v;
        bus.LOAD  = 1'b1;
        wait_cyc(n);
        bus.LOAD  = 1'b0;
    endtask

    initial begin
        bus.VALUE    = 16'h0000;
        bus.LOAD     = 1'b0;
        bus.BLANK_LZ = 1'b0;
        bus.BLINK_EN = 4'b0000;

        // Reset, idle scan of 0000 with FRAME every 16 cycles
        do_reset();
        push_frame(0, C0, C0, C0, C0, 4'b1111, 16, "idle");
        push_frame(1, C0, C0, C0, C0, 4'b1111, 16, "idle");
        push_frame(2, C0, C0, C0, C0, 4'b1111, 16, "idle");

        // Mid-frame LOAD shows only from the next frame
        push_frame(3, C0, C0, C0, C0, 4'b1111, 16, "load_hold");
        push_frame(4, C1, CA, C3, CF, 4'b1111, 16, "load_1a3f");
        load_at(54, 16'h1A3F);

        // Leading-zero suppression
        push_frame(5, C0, C0, C4, C0, 4'b0011, 16, "lz_0040");
        push_frame(6, C0, C0, C0, C0, 4'b0001, 16, "lz_0000");
        wait_cyc(69);
        bus.BLANK_LZ = 1'b1;
        load_at(70, 16'h0040);
        load_at(90, 16'h0000);
        wait_drain();

        // Blink on digit 0: lit 2 frames, blank 2 frames
        bus.BLANK_LZ = 1'b0;
        bus.BLINK_EN = 4'b0001;
        do_reset();
        push_frame(0, C0, C0, C0, C0, 4'b1111, 16, "blink");
        push_frame(1, C0, C0, C0, C0, 4'b1111, 16, "blink");
        push_frame(2, C0, C0, C0, C0, 4'b1110, 16, "blink");
        push_frame(3, C0, C0, C0, C0, 4'b1110, 16, "blink");
        push_frame(4, C0, C0, C0, C0, 4'b1111, 16, "blink");
        push_frame(5, C0, C0, C0, C0, 4'b1111, 16, "blink");

        // Newest-wins pending plus LOAD exactly in the wrap cycle
        push_frame(6, C0, C0, C0, C0, 4'b1111, 16, "multi_hold");
        push_frame(7, C3, C3, C3, C3, 4'b1111, 16, "wrap_load");
        push_frame(8, C3, C3, C3, C3, 4'b1111, 16, "wrap_keep");
        wait_cyc(95);
        bus.BLINK_EN = 4'b0000;
        load_at(100, 16'h1111);
        load_at(104, 16'h2222);
        load_at(112, 16'h3333);

        // Reset mid-slot discards a pending value
        push_frame(9, C3, C3, C3, C3, 4'b1111, 6, "pre_rst");
        load_at(147, 16'h5555);
        wait_cyc(150);
        do_reset();
        push_frame(0, C0, C0, C0, C0, 4'b1111, 16, "post_rst");
        push_frame(1, C0, C0, C0, C0, 4'b1111, 16, "post_rst");
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
